// File: rtl/hack_exec_ctrl_if.sv
// Bundle between the Hack execution controller and its instruction source,
// data memory and registered ALU; the controller side is the master.
interface hack_exec_ctrl_if #(
    parameter int PC_WIDTH = 15
);
    // instruction fetch
    logic                instr_req;
    logic [PC_WIDTH-1:0] instr_addr;
    logic                instr_valid;
    logic [15:0]         instr_data;

    // data memory
    logic                mem_rd;
    logic                mem_we;
    logic [15:0]         mem_addr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata;

    // registered ALU
    logic [6:0]          alu_op;
    logic [15:0]         alu_x;
    logic [15:0]         alu_y;
    logic [15:0]         alu_result;

    // architectural state for observation
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         a_reg;
    logic [15:0]         d_reg;

    modport master (
        output instr_req, instr_addr,
        input  instr_valid, instr_data,
        output mem_rd, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output alu_op, alu_x, alu_y,
        input  alu_result,
        output pc, a_reg, d_reg
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_valid, instr_data,
        input  mem_rd, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  alu_op, alu_x, alu_y,
        output alu_result,
        input  pc, a_reg, d_reg
    );
endinterface

// File: rtl/hack_exec_ctrl.sv
// Hack-style CPU execution controller: owns PC/A/D and sequences
// FETCH -> DECODE -> (MEMRD) -> EXEC -> WB around an external registered ALU.
module hack_exec_ctrl #(
    parameter int                  PC_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    hack_exec_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEMRD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_target;
    logic [15:0]         a_q;
    logic [15:0]         d_q;
    logic [15:0]         ir_q;
    logic [15:0]         m_q;

    // instruction fields
    logic                is_c;
    logic                sel_m;
    logic [5:0]          comp;
    logic [2:0]          dest;
    logic [2:0]          jmp;

    // writeback flags
    logic                res_neg;
    logic                res_zero;
    logic                res_pos;
    logic                take;

    logic                instr_req_c;
    logic                mem_rd_c;
    logic                mem_we_c;

    assign is_c  = ir_q[15];
    assign sel_m = ir_q[12];
    assign comp  = ir_q[11:6];
    assign dest  = ir_q[5:3];
    assign jmp   = ir_q[2:0];

    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign jump_target = a_q[PC_WIDTH-1:0];

    assign res_neg  = bus.alu_result[15];
    assign res_zero = (bus.alu_result == 16'h0000);
    assign res_pos  = !res_neg && !res_zero;
    assign take     = (jmp[2] && res_neg) || (jmp[1] && res_zero) || (jmp[0] && res_pos);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_c) begin
                    state_nxt = ST_FETCH;
                end else if (sel_m) begin
                    state_nxt = ST_MEMRD;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_MEMRD: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_WB;
            ST_WB:    state_nxt = ST_FETCH;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // strobe outputs; reset overrides whatever state the register holds
    always_comb begin
        instr_req_c = 1'b0;
        mem_rd_c    = 1'b0;
        mem_we_c    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH:  instr_req_c = 1'b1;
                ST_DECODE: mem_rd_c    = is_c && sel_m;
                ST_WB:     mem_we_c    = is_c && dest[0];
                default: ;
            endcase
        end
    end

    // architectural registers; WB reads a_q before its own update lands
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            ir_q <= 16'h0000;
            m_q  <= 16'h0000;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bus.instr_valid) begin
                        ir_q <= bus.instr_data;
                    end
                end
                ST_DECODE: begin
                    if (!is_c) begin
                        a_q  <= {1'b0, ir_q[14:0]};
                        pc_q <= pc_inc;
                    end
                end
                ST_MEMRD: begin
                    m_q <= bus.mem_rdata;
                end
                ST_WB: begin
                    if (dest[2]) begin
                        a_q <= bus.alu_result;
                    end
                    if (dest[1]) begin
                        d_q <= bus.alu_result;
                    end
                    pc_q <= take ? jump_target : pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_req  = instr_req_c;
    assign bus.instr_addr = pc_q;

    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = a_q;
    assign bus.mem_wdata = bus.alu_result;

    assign bus.alu_op = {1'b0, comp};
    assign bus.alu_x  = d_q;
    assign bus.alu_y  = sel_m ? m_q : a_q;

    assign bus.pc    = pc_q;
    assign bus.a_reg = a_q;
    assign bus.d_reg = d_q;

    a_no_rd_we_overlap : assert property (@(posedge clk) !(bus.mem_rd && bus.mem_we));
    a_legal_state      : assert property (@(posedge clk) disable iff (rst) state <= ST_WB);

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Bench for hack_exec_ctrl: directed vector table, reset/wrap sequences and
// randomized programs checked against an instruction-level model.
module tb_hack_exec_ctrl;

    localparam int PW = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hack_exec_ctrl_if #(.PC_WIDTH(PW)) bus_if ();

    hack_exec_ctrl #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] dmem    [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          mem_init_done = 1'b0;
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [15:0] poke_data;

    int          we_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    int          op6_cnt = 0;
    logic [15:0] we_addr;
    logic [15:0] we_data;

    logic [PW-1:0] tb_pc;

    // Hack ALU by mnemonic; unknown comp codes yield zero
    function automatic logic [15:0] alu_fn(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'h2A: return 16'h0000;
            6'h3F: return 16'h0001;
            6'h3A: return 16'hFFFF;
            6'h0C: return x;
            6'h30: return y;
            6'h0D: return ~x;
            6'h31: return ~y;
            6'h0F: return -x;
            6'h33: return -y;
            6'h1F: return x + 16'd1;
            6'h37: return y + 16'd1;
            6'h0E: return x - 16'd1;
            6'h32: return y - 16'd1;
            6'h02: return x + y;
            6'h13: return x - y;
            6'h07: return y - x;
            6'h00: return x & y;
            6'h15: return x | y;
            default: return 16'h0000;
        endcase
    endfunction

    // data memory (1-cycle read) and registered ALU
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) dmem[i] = 16'(i * 7 + 3);
            mem_init_done = 1'b1;
        end
        if (poke_en) dmem[poke_addr] = poke_data;
        if (bus_if.mem_rd) bus_if.mem_rdata <= dmem[bus_if.mem_addr];
        if (bus_if.mem_we) dmem[bus_if.mem_addr] = bus_if.mem_wdata;
        bus_if.alu_result <= alu_fn(bus_if.alu_op[5:0], bus_if.alu_x, bus_if.alu_y);
    end

    always @(negedge clk) begin
        if (bus_if.mem_we) begin
            we_cnt++;
            we_addr = bus_if.mem_addr;
            we_data = bus_if.mem_wdata;
        end
        if (bus_if.mem_rd) rd_cnt++;
        if (bus_if.mem_rd && bus_if.mem_we) both_cnt++;
        if (bus_if.alu_op[6]) op6_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge where
    // instr_req is back, with lat = cycles from accept to that point.
    task automatic run_instr(input logic [15:0] ins, input int gap, output int lat);
        int n;
        bus_if.instr_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus_if.instr_valid = 1'b1;
        bus_if.instr_data  = ins;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!bus_if.instr_req && n < 20) begin
            bus_if.instr_valid = 1'b1;
            bus_if.instr_data  = 16'($urandom);
            @(negedge clk);
            n++;
        end
        bus_if.instr_valid = 1'b0;
        lat = n;
    endtask

    task automatic poke(input logic [15:0] addr, input logic [15:0] data);
        poke_addr = addr;
        poke_data = data;
        poke_en   = 1'b1;
        ref_mem[addr] = data;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic set_a(input logic [15:0] v);
        int l;
        run_instr({1'b0, v[14:0]}, 0, l);
        tb_pc = tb_pc + 1'b1;
    endtask

    task automatic set_d(input logic [15:0] v);
        int l;
        if (v == 16'hFFFF) begin
            run_instr(16'hEE90, 0, l);
            tb_pc = tb_pc + 1'b1;
        end else begin
            set_a(v);
            run_instr(16'hEC10, 0, l);
            tb_pc = tb_pc + 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tb_pc = '0;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pre_a;
        logic [15:0] pre_d;
        logic [15:0] pre_m;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
        bit          exp_we;
        logic [15:0] exp_wdata;
        bit          exp_rd;
        bit          exp_take;
        int          exp_lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    logic [5:0] comps [18];

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [5:0]  c;
        int          k;
        r = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k < 3) return {1'b0, r[14:0]};
        if (k == 9) c = 6'($urandom);
        else        c = comps[$urandom_range(0, 17)];
        return {1'b1, r[14:12], c, r[5:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          v;
        int            lat;
        int            we0;
        int            rd0;
        logic [PW-1:0] exp_pc;
        logic [15:0]   ins;
        logic [15:0]   ma;
        logic [15:0]   md;
        logic [PW-1:0] mpc;
        logic [15:0]   y;
        logic [15:0]   r;
        bit            tk;
        int            elat;

        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i * 7 + 3);
        comps = '{6'h2A, 6'h3F, 6'h3A, 6'h0C, 6'h30, 6'h0D, 6'h31, 6'h0F, 6'h33,
                  6'h1F, 6'h37, 6'h0E, 6'h32, 6'h02, 6'h13, 6'h07, 6'h00, 6'h15};

        //          ins       pre_a     pre_d     pre_m     exp_a     exp_d   we  wdata    rd  take lat
        vecs[0] = '{16'hEC10, 16'h0005, 16'h0000, 16'h1111, 16'h0005, 16'h0005, 0, 16'h0000, 0, 0, 4};
        vecs[1] = '{16'hE7C8, 16'h0005, 16'h0005, 16'h2222, 16'h0005, 16'h0005, 1, 16'h0006, 0, 0, 4};
        vecs[2] = '{16'hFC10, 16'h0005, 16'h0123, 16'h0006, 16'h0005, 16'h0006, 0, 16'h0000, 1, 0, 5};
        vecs[3] = '{16'hE302, 16'h0010, 16'h0000, 16'h3333, 16'h0010, 16'h0000, 0, 16'h0000, 0, 1, 4};
        vecs[4] = '{16'hE301, 16'h0010, 16'h0000, 16'h3333, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 4};
        vecs[5] = '{16'hE304, 16'h0010, 16'hFFFF, 16'h3333, 16'h0010, 16'hFFFF, 0, 16'h0000, 0, 1, 4};
        vecs[6] = '{16'h1234, 16'h0007, 16'h0022, 16'h4444, 16'h1234, 16'h0022, 0, 16'h0000, 0, 0, 2};
        vecs[7] = '{16'hE32F, 16'h0020, 16'h0040, 16'h5555, 16'h0040, 16'h0040, 1, 16'h0040, 0, 1, 4};
        vecs[8] = '{16'hE301, 16'h0030, 16'h0001, 16'h6666, 16'h0030, 16'h0001, 0, 16'h0000, 0, 1, 4};
        vecs[9] = '{16'hFDF8, 16'h0044, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 1, 16'h8000, 1, 0, 5};

        bus_if.instr_valid = 1'b0;
        bus_if.instr_data  = 16'h0000;
        poke_en   = 1'b0;
        poke_addr = 16'h0000;
        poke_data = 16'h0000;

        // reset and idle fetch
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_instr_req", 32'(bus_if.instr_req), 0);
            check("rst_mem_strobes", {30'd0, bus_if.mem_rd, bus_if.mem_we}, 0);
        end
        rst = 1'b0;
        tb_pc = '0;
        #1;
        check("rst_pc", 32'(bus_if.pc), 0);
        check("rst_a", 32'(bus_if.a_reg), 0);
        check("rst_d", 32'(bus_if.d_reg), 0);
        check("post_rst_req", 32'(bus_if.instr_req), 1);
        repeat (3) @(negedge clk);
        check("idle_req", 32'(bus_if.instr_req), 1);
        check("idle_pc", 32'(bus_if.pc), 0);

        // directed vector table
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            set_d(v.pre_d);
            set_a(v.pre_a);
            poke(v.pre_a, v.pre_m);
            check($sformatf("v%0d_fetch_addr", i), 32'(bus_if.instr_addr), 32'(tb_pc));
            we0 = we_cnt;
            rd0 = rd_cnt;
            run_instr(v.ins, i % 3, lat);
            exp_pc = v.exp_take ? v.pre_a[PW-1:0] : tb_pc + 1'b1;
            tb_pc  = exp_pc;
            check($sformatf("v%0d_a", i), 32'(bus_if.a_reg), 32'(v.exp_a));
            check($sformatf("v%0d_d", i), 32'(bus_if.d_reg), 32'(v.exp_d));
            check($sformatf("v%0d_pc", i), 32'(bus_if.pc), 32'(exp_pc));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("v%0d_we_cnt", i), 32'(we_cnt - we0), 32'(v.exp_we));
            check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - rd0), 32'(v.exp_rd));
            if (v.exp_we) begin
                check($sformatf("v%0d_we_addr", i), 32'(we_addr), 32'(v.pre_a));
                check($sformatf("v%0d_we_data", i), 32'(we_data), 32'(v.exp_wdata));
                ref_mem[v.pre_a] = v.exp_wdata;
            end
        end

        // reset while M=D+1 is in EXEC: nothing may commit
        set_d(16'h0005);
        set_a(16'h0005);
        we0 = we_cnt;
        bus_if.instr_valid = 1'b1;
        bus_if.instr_data  = 16'hE7C8;
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_pc", 32'(bus_if.pc), 0);
        check("rstmid_a", 32'(bus_if.a_reg), 0);
        check("rstmid_d", 32'(bus_if.d_reg), 0);
        check("rstmid_req", 32'(bus_if.instr_req), 0);
        rst = 1'b0;
        tb_pc = '0;
        repeat (3) @(negedge clk);
        check("rstmid_no_we", 32'(we_cnt - we0), 0);
        check("rstmid_req_back", 32'(bus_if.instr_req), 1);

        // PC wrap at 0x7FFF
        set_a(16'h7FFF);
        run_instr(16'hEA87, 1, lat);
        check("wrap_jmp_pc", 32'(bus_if.pc), 32'h7FFF);
        check("wrap_jmp_lat", 32'(lat), 4);
        run_instr(16'h0001, 0, lat);
        check("wrap_pc", 32'(bus_if.pc), 0);
        check("wrap_a", 32'(bus_if.a_reg), 1);

        // randomized programs against instruction-level model
        do_reset();
        ma  = 16'h0000;
        md  = 16'h0000;
        mpc = '0;
        for (int n = 0; n < 300; n++) begin
            ins = rand_instr();
            check("rnd_fetch_addr", 32'(bus_if.instr_addr), 32'(mpc));
            we0 = we_cnt;
            rd0 = rd_cnt;
            run_instr(ins, $urandom_range(0, 2), lat);
            if (!ins[15]) begin
                ma   = {1'b0, ins[14:0]};
                mpc  = mpc + 1'b1;
                elat = 2;
            end else begin
                y    = ins[12] ? ref_mem[ma] : ma;
                r    = alu_fn(ins[11:6], md, y);
                elat = ins[12] ? 5 : 4;
                if (ins[3]) begin
                    check("rnd_we_addr", 32'(we_addr), 32'(ma));
                    check("rnd_we_data", 32'(we_data), 32'(r));
                    ref_mem[ma] = r;
                end
                tk  = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) || (ins[0] && $signed(r) > 0);
                mpc = tk ? ma[PW-1:0] : mpc + 1'b1;
                if (ins[5]) ma = r;
                if (ins[4]) md = r;
            end
            check("rnd_lat", 32'(lat), 32'(elat));
            check("rnd_we_cnt", 32'(we_cnt - we0), 32'(ins[15] && ins[3]));
            check("rnd_rd_cnt", 32'(rd_cnt - rd0), 32'(ins[15] && ins[12]));
            check("rnd_pc", 32'(bus_if.pc), 32'(mpc));
            check("rnd_a", 32'(bus_if.a_reg), 32'(ma));
            check("rnd_d", 32'(bus_if.d_reg), 32'(md));
        end

        check("rd_we_overlap", 32'(both_cnt), 0);
        check("alu_op6_set", 32'(op6_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_exec_ctrl.md
Name: hack_exec_ctrl

Overview:
Multi-cycle fetch/decode/writeback controller for the 16-bit Hack-style CPU. It owns PC, A and D. It fetches instructions over a valid handshake and decodes A-/C-instructions. It drives the registered ALU (opcode, x, y) and consumes its one-cycle-late result. It then performs destination writeback (A/D/M) and jump evaluation.

Parameters:
PC_WIDTH, 15, width of PC and instruction address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
instr_req  output  1  high in FETCH: requesting instruction at instr_addr
instr_addr  output  PC_WIDTH  current PC
instr_valid  input  1  instr_data valid; accepted when instr_req&&instr_valid
instr_data  input  16  instruction word
mem_rd  output  1  data-memory read strobe (1-cycle synchronous read)
mem_we  output  1  data-memory write strobe (single-cycle pulse)
mem_addr  output  16  data address; always equals current A
mem_wdata  output  16  write data; equals alu_result
mem_rdata  input  16  read data, valid the cycle after mem_rd
alu_op  output  7  {1'b0, comp[5:0]} to ALU
alu_x  output  16  D register
alu_y  output  16  A register (a=0) or latched M (a=1)
alu_result  input  16  registered ALU output
pc  output  PC_WIDTH  program counter (debug/observe)
a_reg  output  16  A register
d_reg  output  16  D register

Behaviour:
- Instruction format: bit15=0 → A-instr. bit15=1 → C-instr: [12]=a, [11:6]=comp, [5:3]=dest{A,D,M}, [2:0]=jump{lt,eq,gt}. Bits [14:13] are ignored.
- Reset (rst high at posedge): pc=RESET_PC, A=0, D=0, ir=0, m_latch=0, state=FETCH.
- While rst is high, instr_req, mem_rd and mem_we are forced 0.
- Reset mid-instruction aborts it. No write or PC change completes.
- States:
  - FETCH: instr_req=1. Stay while !instr_valid. On accept, ir<=instr_data and go to DECODE.
  - DECODE:
    - A-instr: A<={1'b0,ir[14:0]}, pc<=pc+1, go to FETCH.
    - C-instr with a=1: mem_rd=1 for this cycle, go to MEMRD.
    - C-instr with a=0: go to EXEC.
  - MEMRD: m_latch<=mem_rdata, go to EXEC.
  - EXEC: alu_op/alu_x/alu_y are valid and stable. The ALU registers its result at the end of this cycle. Go to WB.
  - WB: consume alu_result, then go to FETCH. In this cycle:
    - dest[5]: A<=alu_result.
    - dest[4]: D<=alu_result.
    - dest[3]: mem_we=1 with mem_addr = old A.
    - Flags: neg=alu_result[15], zero=(alu_result==0), pos=!neg&&!zero.
    - take = (j[2]&neg)|(j[1]&zero)|(j[0]&pos).
    - pc <= take ? old A[PC_WIDTH-1:0] : pc+1.
- WB uses pre-update A for the M address and the jump target, even when dest[5]=1 (e.g. AM=, A;JMP).
- alu_op[6] is always 0. alu_x/alu_y are driven combinationally from the registers in every state; only EXEC/WB values are meaningful.
- Latency:
  - A-instr: 2 cycles plus fetch wait.
  - C-instr, a=0: 4 cycles plus fetch wait.
  - C-instr, a=1: 5 cycles plus fetch wait.
- PC wraps modulo 2^PC_WIDTH (0x7FFF+1 → 0).
- mem_rd and mem_we are never asserted in the same cycle. Each asserts at most once per instruction.
- instr_valid is ignored outside FETCH.
- Unlisted comp codes pass through unchanged; the ALU yields 0.

Test Plan:
1. rst high 2 cycles, then low → pc=0, a_reg=0, d_reg=0, instr_req=0 during reset and 1 the first cycle after. Holding instr_valid=0 for 3 cycles keeps the block in FETCH with pc unchanged.
2. Fetch 0x0005 then 0xEC10 (D=A) → a_reg=0x0005, pc=1, then d_reg=0x0005, pc=2. No mem_rd or mem_we pulses.
3. A=5, D=5, fetch 0xE7C8 (M=D+1) → exactly one mem_we cycle with mem_addr=0x0005, mem_wdata=0x0006, in WB. D unchanged.
4. mem[5]=0x0006, A=5, fetch 0xFC10 (D=M) → mem_rd pulse with mem_addr=5, then d_reg=0x0006, and 5 cycles from accept to next FETCH.
5. A=0x0010, D=0: 0xE302 (D;JEQ) → pc=0x0010. Repeat with 0xE301 (D;JGT) → pc=old pc+1. D=0xFFFF with 0xE304 (D;JLT) → pc=0x0010.
6. Assert rst during EXEC of 0xE7C8 → no mem_we, pc=RESET_PC, A=D=0. pc=0x7FFF with an A-instr → pc wraps to 0.
